// File: rtl/core_pkg.sv
// Shared core definitions: default data width, register-file FSM encoding and the hardwired zero index.
package core_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits; alloc beats write-back and flush, and the next-state value is exposed per read port.
module rf_scoreboard
    import core_pkg::*;
#(
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_pend_c
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Priority low to high: hold, flush, write-back clear, alloc set.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end
        if (wr_en) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (alloc_en && (alloc_addr != AW'(ZERO_REG))) begin
            pend_d[alloc_addr] = 1'b1;
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_comb begin
        rd_pend_c = '0;
        for (int p = 0; p < int'(NRD); p++) begin
            rd_pend_c[p] = pend_d[rd_addr[p*AW +: AW]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, pending scoreboard and a post-reset clear sequencer.
module regfile_mp
    import core_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_done_o,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic                alloc_valid_i,
    input  logic [AW-1:0]       alloc_addr_i,
    input  logic                flush_i,
    input  logic [NRD-1:0]      rd_en_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o
);

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW-1:0]   clr_idx_q;
    logic [AW-1:0]   clr_idx_d;
    logic            run;
    logic            wr_en;
    logic [NRD-1:0]  pend_c;
    logic [NRD*XLEN-1:0] rd_val_c;
    logic [NRD-1:0]  busy_c;
    logic [XLEN-1:0] mem [NREG];

    assign run         = (state_q == ST_RUN);
    assign wr_ready_o  = run;
    assign init_done_o = run;
    assign wr_en       = wr_valid_i & run & (wr_addr_i != AW'(ZERO_REG));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Clear sweeps every index once, then RUN holds until the next reset.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Storage has no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_en) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr_i),
        .alloc_en   (alloc_valid_i & run),
        .alloc_addr (alloc_addr_i),
        .flush      (flush_i & run),
        .rd_addr    (rd_addr_i),
        .rd_pend_c  (pend_c)
    );

    // Read mux: zero register and CLEAR read as 0; a same-edge write to the index wins over the array.
    always_comb begin
        rd_val_c = '0;
        busy_c   = '0;
        for (int p = 0; p < int'(NRD); p++) begin
            if (run && (rd_addr_i[p*AW +: AW] != AW'(ZERO_REG))) begin
                if (wr_en && (wr_addr_i == rd_addr_i[p*AW +: AW])) begin
                    rd_val_c[p*XLEN +: XLEN] = wr_data_i;
                end else begin
                    rd_val_c[p*XLEN +: XLEN] = mem[rd_addr_i[p*AW +: AW]];
                end
                busy_c[p] = pend_c[p];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_o <= '0;
            rd_busy_o <= '0;
        end else begin
            for (int p = 0; p < int'(NRD); p++) begin
                if (rd_en_i[p]) begin
                    rd_data_o[p*XLEN +: XLEN] <= rd_val_c[p*XLEN +: XLEN];
                    rd_busy_o[p]              <= busy_c[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear timing, read/write, bypass, scoreboard, stall and mid-run reset.
module tb_regfile_mp;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic                clk;
    logic                reset;
    logic                init_done_o;
    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [AW-1:0]       wr_addr_i;
    logic [XLEN-1:0]     wr_data_i;
    logic                alloc_valid_i;
    logic [AW-1:0]       alloc_addr_i;
    logic                flush_i;
    logic [NRD-1:0]      rd_en_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;

    int errors = 0;
    int checks = 0;

    regfile_mp #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_done_o   (init_done_o),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .alloc_valid_i (alloc_valid_i),
        .alloc_addr_i  (alloc_addr_i),
        .flush_i       (flush_i),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .rd_busy_o     (rd_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_en_i[p]           = 1'b1;
        rd_addr_i[p*AW +: AW] = a;
    endtask

    task automatic idle();
        wr_valid_i    = 1'b0;
        alloc_valid_i = 1'b0;
        flush_i       = 1'b0;
        rd_en_i       = '0;
    endtask

    function automatic logic [XLEN-1:0] dat(input int p);
        return rd_data_o[p*XLEN +: XLEN];
    endfunction

    task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_valid_i = 1'b1;
        wr_addr_i  = a;
        wr_data_i  = d;
    endtask

    task automatic wait_init(input string tag, output int cyc);
        cyc = 0;
        while (!init_done_o && cyc < 100) begin
            step();
            cyc++;
        end
        check(tag, 64'(cyc), 64'(NREG));
    endtask

    initial begin
        int cyc;
        bit stall_ok;

        reset = 1'b1;
        wr_addr_i = '0;
        wr_data_i = '0;
        alloc_addr_i = '0;
        rd_addr_i = '0;
        idle();

        // Reset values
        #3;
        check("rst_init_done", 64'(init_done_o), 64'd0);
        check("rst_wr_ready", 64'(wr_ready_o), 64'd0);
        check("rst_rd_data", 64'(rd_data_o), 64'd0);
        check("rst_rd_busy", 64'(rd_busy_o), 64'd0);
        step();
        step();
        reset = 1'b0;

        // 1. Clear takes exactly NREG edges, then all entries read 0
        wait_init("init_cycles", cyc);
        for (int i = 0; i < int'(NREG); i++) begin
            idle();
            set_rd(0, AW'(i));
            step();
            check($sformatf("clear_x%0d", i), 64'(dat(0)), 64'd0);
        end

        // 2. Write then read on both ports; x0 is hardwired
        idle();
        write(5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd5);
        step();
        check("x5_p0", 64'(dat(0)), 64'hDEAD_BEEF);
        check("x5_p1", 64'(dat(1)), 64'hDEAD_BEEF);
        check("x5_busy", 64'(rd_busy_o), 64'd0);
        idle();
        check("ready_run", 64'(wr_ready_o), 64'd1);
        write(5'd0, 32'h1234);
        step();
        idle();
        set_rd(0, 5'd0);
        step();
        check("x0_zero", 64'(dat(0)), 64'd0);

        // 3. Bypass: same-edge write and read of x7 returns the new value
        idle();
        write(5'd7, 32'h11);
        step();
        idle();
        write(5'd7, 32'hA5A5_A5A5);
        set_rd(1, 5'd7);
        set_rd(0, 5'd5);
        step();
        check("bypass_p1", 64'(dat(1)), 64'hA5A5_A5A5);
        check("bypass_p0", 64'(dat(0)), 64'hDEAD_BEEF);

        // 4. Scoreboard
        idle();
        alloc_valid_i = 1'b1;
        alloc_addr_i  = 5'd9;
        step();
        idle();
        set_rd(0, 5'd9);
        step();
        check("alloc_busy", 64'(rd_busy_o[0]), 64'd1);
        idle();
        write(5'd9, 32'd3);
        set_rd(0, 5'd9);
        step();
        check("wr_clr_busy", 64'(rd_busy_o[0]), 64'd0);
        check("wr_clr_data", 64'(dat(0)), 64'd3);
        idle();
        write(5'd9, 32'd7);
        alloc_valid_i = 1'b1;
        alloc_addr_i  = 5'd9;
        step();
        idle();
        set_rd(0, 5'd9);
        step();
        check("alloc_wins_busy", 64'(rd_busy_o[0]), 64'd1);
        check("alloc_wins_data", 64'(dat(0)), 64'd7);
        idle();
        flush_i = 1'b1;
        set_rd(0, 5'd9);
        step();
        check("flush_busy", 64'(rd_busy_o[0]), 64'd0);
        idle();
        flush_i       = 1'b1;
        alloc_valid_i = 1'b1;
        alloc_addr_i  = 5'd10;
        set_rd(1, 5'd10);
        step();
        check("alloc_over_flush", 64'(rd_busy_o[1]), 64'd1);
        idle();
        alloc_valid_i = 1'b1;
        alloc_addr_i  = 5'd0;
        set_rd(1, 5'd0);
        step();
        check("alloc_x0_ignored", 64'(rd_busy_o[1]), 64'd0);

        // 6. Reset between edges after writing x4
        idle();
        write(5'd4, 32'h99);
        step();
        idle();
        set_rd(0, 5'd4);
        step();
        check("x4_before_rst", 64'(dat(0)), 64'h99);
        idle();
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_data", 64'(rd_data_o), 64'd0);
        check("async_rst_busy", 64'(rd_busy_o), 64'd0);
        check("async_rst_init", 64'(init_done_o), 64'd0);
        check("async_rst_ready", 64'(wr_ready_o), 64'd0);
        #1;
        reset = 1'b0;

        // 5. Write to x3 held through CLEAR; enabled reads in CLEAR return 0
        write(5'd3, 32'h55);
        set_rd(1, 5'd4);
        step();
        check("clear_read_zero", 64'(dat(1)), 64'd0);
        rd_en_i = '0;
        cyc = 1;
        stall_ok = 1'b1;
        while (!init_done_o && cyc < 100) begin
            if (wr_ready_o) stall_ok = 1'b0;
            step();
            cyc++;
        end
        check("reclear_cycles", 64'(cyc), 64'(NREG));
        check("stall_ready_low", 64'(stall_ok), 64'd1);
        check("ready_after_clear", 64'(wr_ready_o), 64'd1);
        step();
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd4);
        step();
        check("x3_after_stall", 64'(dat(0)), 64'h55);
        check("x4_cleared", 64'(dat(1)), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
